vga_fill_apb_master: RTL and testbench
======================================

// Module: vga_fill_apb_master
// PURPOSE
//  APB initiator that fills a rectangle of the VGA framebuffer with one colour.
//  Takes a fill command from a valid/ready port and issues one APB write per pixel, in raster order.
//  Sits between the SoC control logic and the APB-attached VGA framebuffer slave.
//  The framebuffer is word-addressed: pixel (x,y) lives at BASE_ADDR + y*STRIDE + x.
// PARAMETERS
//  BASE_ADDR  32'h0  framebuffer word address of pixel (0,0)
//  STRIDE     1024   words per framebuffer row; matches the slave's {y[8:0],x[9:0]} indexing
//  H_RES      640    visible columns; x >= H_RES is clipped
//  V_RES      480    visible rows; y >= V_RES is clipped
// PORTS
//  clock        in   1   single clock; all logic is posedge
//  reset        in   1   synchronous, active-low reset (0 = reset)
//  cmd_valid    in   1   fill command present
//  cmd_ready    out  1   high only in IDLE
//  cmd_x0       in   10  left column
//  cmd_y0       in   9   top row
//  cmd_w        in   11  width in pixels (0 allowed)
//  cmd_h        in   10  height in pixels (0 allowed)
//  cmd_color    in   24  {R,G,B}, 8 bits each
//  busy         out  1   command in progress (SETUP/ACCESS/DONE)
//  done         out  1   1-cycle pulse at command end
//  err          out  1   sticky slave error; only with FILL_PSLVERR_ABORT_EN
//  pix_count    out  20  writes completed for the current command
//  out_paddr    out  32  APB address      | out_psel   out 1 | out_penable out 1
//  out_pprot    out  3   always 3'b000    | out_pwrite out 1, always 1
//  out_pwdata   out  32  {8'h00,cmd_color} | out_pstrb  out 4, always 4'hF
//  out_pready   in   1   slave ready      | out_prdata in 32, unused | out_pslverr in 1
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; psel=penable=0; busy=done=err=0; pix_count=0; cmd_ready=1 after reset.
//  Reset mid-transfer drops psel/penable on the next edge. Any in-flight APB access is abandoned.
//  FSM IDLE->SETUP->ACCESS->(SETUP|DONE)->IDLE:
//   IDLE: cmd_valid&cmd_ready latches the command. Clipping is applied at accept:
//     ew = (x0>=H_RES) ? 0 : min(w, H_RES-x0); eh = (y0>=V_RES) ? 0 : min(h, V_RES-y0).
//     pix_count<=0, err<=0. If ew==0 or eh==0, go to DONE (no APB traffic); else go to SETUP with x=y=0.
//   SETUP: psel=1, penable=0, paddr=BASE_ADDR+(y0+y)*STRIDE+(x0+x), computed mod 2^32. Always exactly 1 cycle, then ACCESS.
//   ACCESS: psel=1, penable=1; paddr/pwdata held stable. Stay while pready=0 (no timeout).
//     On pready=1: pix_count++ and advance x. If x hits ew, x<=0 and y++. If that was the last pixel, go to DONE; else go to SETUP.
//   DONE: psel=penable=0, done=1 for exactly 1 cycle, busy=1; next state IDLE.
//  Back-to-back writes keep psel high and drop penable for the SETUP cycle. Minimum 2 cycles/pixel.
//  cmd_* are sampled only at accept; later changes have no effect. cmd_valid outside IDLE is ignored.
//  Address arithmetic is 32-bit unsigned; wrap-around is allowed and not flagged.
// CONFIGURATION
//  FILL_PSLVERR_ABORT_EN defined:
//   out_pslverr is sampled with pready=1 in ACCESS. If high: err<=1, the remaining pixels are skipped,
//   and the FSM goes to DONE. The failing write is not counted in pix_count. err is held until the next accept.
//  Not defined: out_pslverr is ignored, err tied 0, and every pixel is always written.
// STRUCTURE
//  Package vga_fill_pkg: state_t enum {IDLE,SETUP,ACCESS,DONE}; APB_PROT_DEF=3'b000; APB_STRB_ALL=4'hF.
//  Sub-module fill_raster_counter: x/y counters, last-pixel flag, and the paddr computation.
//  Top level holds the FSM, command latch and APB output registers.
// TESTING
//  1. w=3,h=2,x0=10,y0=5,color=24'h112233, pready always 1 -> 6 writes, paddr 0x140A,0x140B,0x140C,0x180A,0x180B,0x180C;
//     pwdata=0x00112233; 12 cycles of psel; done pulses once; pix_count=6.
//  2. Slave holds pready=0 for 3 cycles on each access, w=h=1 -> penable high 4 cycles, paddr/pwdata stable throughout, then done.
//  3. x0=638,w=10,y0=479,h=4 -> clipped to 2x1 -> paddr 0x77E7E,0x77E7F; pix_count=2.
//  4. w=0 (also x0=700) -> no psel assertion; done one cycle after accept; pix_count=0.
//  5. With FILL_PSLVERR_ABORT_EN, w=4,h=1, pslverr=1 on write 2 -> err=1, pix_count=1, no 3rd SETUP.
//     Without the macro: 4 writes, err=0.
//  6. reset=0 during ACCESS of a 100-pixel fill -> next edge psel=penable=0, cmd_ready=1.
//     A new command afterwards starts from its own x0/y0.

Source files
------------

// File: rtl/vga_fill_apb_master_pkg.sv
// vga_fill_pkg: shared types and constants for the VGA rectangle-fill APB master.
//   state_t      : fill FSM states
//   fill_cmd_t   : command as latched at accept (extent already clipped)
//   clip_span()  : clips a 1-D span [start, start+len) against a resolution
package vga_fill_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [2:0] APB_PROT_DEF = 3'b000;
    localparam logic [3:0] APB_STRB_ALL = 4'hF;

    typedef struct packed {
        logic [9:0]  x0;
        logic [8:0]  y0;
        logic [10:0] ew;     // effective (clipped) width
        logic [9:0]  eh;     // effective (clipped) height
        logic [23:0] color;
    } fill_cmd_t;

    // Span starting off-screen is empty; otherwise it is cut at the screen edge.
    function automatic logic [10:0] clip_span(input logic [31:0] start,
                                              input logic [31:0] len,
                                              input logic [31:0] res);
        logic [31:0] room;
        if (start >= res) return '0;
        room = res - start;
        return 11'((len < room) ? len : room);
    endfunction

endpackage

// File: rtl/vga_fill_apb_master_if.sv
// vga_fill_apb_master_if: fill-command valid/ready port plus the APB write bus.
//   master modport : view of the fill engine (accepts commands, drives APB)
//   slave  modport : view of the environment (issues commands, answers APB)
interface vga_fill_apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0;
    logic [8:0]  cmd_y0;
    logic [10:0] cmd_w;
    logic [9:0]  cmd_h;
    logic [23:0] cmd_color;

    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    modport master (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        output cmd_ready,
        output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
        input  out_pready, out_prdata, out_pslverr
    );

    modport slave (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        input  cmd_ready,
        input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
        output out_pready, out_prdata, out_pslverr
    );
endinterface

// File: rtl/vga_fill_apb_master_fill_raster_counter.sv
// fill_raster_counter: walks (x,y) over the clipped rectangle in raster order
// and forms the framebuffer word address of the current pixel.
//   clock, reset : clock and synchronous active-low reset
//   clear        : restart at (0,0) (command accept)
//   step         : current pixel written, advance
//   x0, y0       : rectangle origin
//   ew, eh       : clipped extent (both non-zero whenever step is used)
//   last         : current pixel is the final one of the rectangle
//   paddr        : BASE_ADDR + (y0+y)*STRIDE + (x0+x), modulo 2^32
module fill_raster_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] STRIDE    = 32'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [9:0]  x0,
    input  logic [8:0]  y0,
    input  logic [10:0] ew,
    input  logic [9:0]  eh,
    output logic        last,
    output logic [31:0] paddr
);
    logic [10:0] x;
    logic [9:0]  y;
    logic        row_end;

    assign row_end = (x == ew - 11'd1);
    assign last    = row_end && (y == eh - 10'd1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (row_end) begin
                x <= '0;
                y <= y + 10'd1;
            end else begin
                x <= x + 11'd1;
            end
        end
    end

    // x/y only move on step, which always leaves ACCESS, so paddr is stable
    // for the whole SETUP/ACCESS pair of a write.
    assign paddr = BASE_ADDR + (32'(y0) + 32'(y)) * STRIDE + 32'(x0) + 32'(x);

endmodule

// File: rtl/vga_fill_apb_master.sv
// vga_fill_apb_master: fills a framebuffer rectangle with one colour by issuing
// one APB write per pixel in raster order.
//   clock, reset : clock and synchronous active-low reset
//   bus          : master modport -- fill command valid/ready + APB write bus
//   busy         : command in progress (SETUP/ACCESS/DONE)
//   done         : 1-cycle pulse at command end
//   err          : sticky slave error (only with FILL_PSLVERR_ABORT_EN)
//   pix_count    : writes completed for the current command
// Optional build macro FILL_PSLVERR_ABORT_EN: abort the fill on a slave error.
module vga_fill_apb_master
    import vga_fill_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] STRIDE    = 32'd1024,
    parameter logic [31:0] H_RES     = 32'd640,
    parameter logic [31:0] V_RES     = 32'd480
) (
    input  logic                    clock,
    input  logic                    reset,
    vga_fill_apb_master_if.master   bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [19:0]             pix_count
);
    state_t      state, state_nxt;
    fill_cmd_t   cmd_q;
    logic [10:0] ew_acc;
    logic [9:0]  eh_acc;
    logic        accept, step, abort, last;
    logic        psel_q, penable_q, done_q;
    logic [31:0] paddr;

    assign ew_acc = clip_span(32'(bus.cmd_x0), 32'(bus.cmd_w), H_RES);
    assign eh_acc = 10'(clip_span(32'(bus.cmd_y0), 32'(bus.cmd_h), V_RES));

    assign accept = (state == IDLE) && bus.cmd_valid;

`ifdef FILL_PSLVERR_ABORT_EN
    logic err_q;
    logic unused_bits;
    assign abort       = (state == ACCESS) && bus.out_pready && bus.out_pslverr;
    assign err         = err_q;
    assign unused_bits = ^bus.out_prdata;
`else
    logic unused_bits;
    assign abort       = 1'b0;
    assign err         = 1'b0;
    assign unused_bits = ^{bus.out_prdata, bus.out_pslverr};
`endif

    // An aborted write is not a completed pixel.
    assign step = (state == ACCESS) && bus.out_pready && !abort;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (ew_acc == '0 || eh_acc == '0) ? DONE : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (bus.out_pready) state_nxt = (abort || last) ? DONE : SETUP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            pix_count <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            // APB strobes registered from the next state so they are glitch-free.
            psel_q    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            penable_q <= (state_nxt == ACCESS);
            done_q    <= (state_nxt == DONE);
            if (accept) begin
                cmd_q     <= '{x0: bus.cmd_x0, y0: bus.cmd_y0, ew: ew_acc, eh: eh_acc,
                               color: bus.cmd_color};
                pix_count <= '0;
            end else if (step) begin
                pix_count <= pix_count + 20'd1;
            end
        end
    end

`ifdef FILL_PSLVERR_ABORT_EN
    always_ff @(posedge clock) begin
        if (!reset)      err_q <= 1'b0;
        else if (accept) err_q <= 1'b0;
        else if (abort)  err_q <= 1'b1;
    end
`endif

    fill_raster_counter #(
        .BASE_ADDR (BASE_ADDR),
        .STRIDE    (STRIDE)
    ) u_raster (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .step  (step),
        .x0    (cmd_q.x0),
        .y0    (cmd_q.y0),
        .ew    (cmd_q.ew),
        .eh    (cmd_q.eh),
        .last  (last),
        .paddr (paddr)
    );

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.out_psel    = psel_q;
    assign bus.out_penable = penable_q;
    assign bus.out_paddr   = paddr;
    assign bus.out_pwdata  = {8'h00, cmd_q.color};
    assign bus.out_pprot   = APB_PROT_DEF;
    assign bus.out_pwrite  = 1'b1;
    assign bus.out_pstrb   = APB_STRB_ALL;

    assign busy = (state != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_vga_fill_apb_master.sv
// tb_vga_fill_apb_master: directed bench for the rectangle-fill APB master.
// Expected writes are queued when a command is issued and checked in order
// as the APB slave model completes each access.
module tb_vga_fill_apb_master;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        busy, done, err;
    logic [19:0] pix_count;

    always #5 clock = ~clock;

    vga_fill_apb_master_if bus ();

    vga_fill_apb_master dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pix_count (pix_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // slave model / monitor state
    int          wait_cycles = 0;
    int          err_idx     = -1;
    int          acc_cnt     = 0;
    int          wr_idx      = 0;
    int          psel_cyc    = 0;
    int          pen_cyc     = 0;
    int          done_cnt    = 0;
    logic        prev_wait   = 1'b0;
    logic [31:0] prev_addr, prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: observed timeout/extra event expected none", tag);
    endtask

    // Responses change on the falling edge; the DUT samples them on the rising edge.
    always @(negedge clock) begin
        if (bus.out_psel && bus.out_penable) begin
            acc_cnt++;
            bus.out_pready  = (acc_cnt > wait_cycles);
            bus.out_pslverr = bus.out_pready && (wr_idx == err_idx);
        end else begin
            acc_cnt         = 0;
            bus.out_pready  = 1'b0;
            bus.out_pslverr = 1'b0;
        end
        bus.out_prdata = 32'hDEAD_BEEF;

        if (bus.out_psel)    psel_cyc++;
        if (bus.out_penable) pen_cyc++;
        if (done)            done_cnt++;

        if (bus.out_psel && bus.out_penable) begin
            if (prev_wait) begin
                check("hold_paddr", bus.out_paddr, prev_addr);
                check("hold_pwdata", bus.out_pwdata, prev_data);
            end
            if (bus.out_pready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("paddr", bus.out_paddr, e.addr);
                    check("pwdata", bus.out_pwdata, e.data);
                    check("pstrb", 32'(bus.out_pstrb), 32'hF);
                    check("pprot", 32'(bus.out_pprot), 32'h0);
                    check("pwrite", 32'(bus.out_pwrite), 32'h1);
                end
                wr_idx++;
                prev_wait = 1'b0;
            end else begin
                prev_wait = 1'b1;
            end
            prev_addr = bus.out_paddr;
            prev_data = bus.out_pwdata;
        end else begin
            prev_wait = 1'b0;
        end
    end

    function automatic int clip(input int s, input int l, input int r);
        if (s >= r) return 0;
        return (l < r - s) ? l : r - s;
    endfunction

    task automatic push(input logic [31:0] a, input logic [23:0] c);
        exp_t e;
        e.addr = a;
        e.data = {8'h00, c};
        exp_q.push_back(e);
    endtask

    task automatic push_rect(input int x0, input int y0, input int w, input int h,
                             input logic [23:0] c);
        int ew, eh;
        ew = clip(x0, w, 640);
        eh = clip(y0, h, 480);
        for (int y = 0; y < eh; y++)
            for (int x = 0; x < ew; x++)
                push(32'((y0 + y) * 1024 + x0 + x), c);
    endtask

    // Present a command at a falling edge; it is accepted at the next rising edge.
    task automatic issue(input int x0, input int y0, input int w, input int h,
                         input logic [23:0] c);
        @(negedge clock);
        psel_cyc      = 0;
        pen_cyc       = 0;
        done_cnt      = 0;
        wr_idx        = 0;
        bus.cmd_x0    = 10'(x0);
        bus.cmd_y0    = 9'(y0);
        bus.cmd_w     = 11'(w);
        bus.cmd_h     = 10'(h);
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = 10'h3FF;   // later changes must not matter
        bus.cmd_color = 24'hFFFFFF;
    endtask

    // Counts falling edges from accept until done; then lets the pulse finish.
    task automatic wait_done(input string tag, input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!done && lat < budget);
        if (!done) fail_now({tag, "_done_timeout"});
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        int lat;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_psel", 32'(bus.out_psel), 0);
        check("rst_penable", 32'(bus.out_penable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_pix", 32'(pix_count), 0);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        reset = 1'b1;

        // 1: 3x2 at (10,5), zero wait states
        push(32'h140A, 24'h112233); push(32'h140B, 24'h112233); push(32'h140C, 24'h112233);
        push(32'h180A, 24'h112233); push(32'h180B, 24'h112233); push(32'h180C, 24'h112233);
        issue(10, 5, 3, 2, 24'h112233);
        wait_done("t1", 200, lat);
        check("t1_psel_cycles", 32'(psel_cyc), 12);
        check("t1_done_pulses", 32'(done_cnt), 1);
        check("t1_pix", 32'(pix_count), 6);
        check("t1_q_empty", 32'(exp_q.size()), 0);
        check("t1_ready", 32'(bus.cmd_ready), 1);

        // 2: single pixel, three wait states
        wait_cycles = 3;
        push_rect(0, 0, 1, 1, 24'hAABBCC);
        issue(0, 0, 1, 1, 24'hAABBCC);
        wait_done("t2", 200, lat);
        check("t2_penable_cycles", 32'(pen_cyc), 4);
        check("t2_psel_cycles", 32'(psel_cyc), 5);
        check("t2_done_pulses", 32'(done_cnt), 1);
        check("t2_pix", 32'(pix_count), 1);
        check("t2_q_empty", 32'(exp_q.size()), 0);
        wait_cycles = 0;

        // 3: clipped at the bottom-right corner to 2x1
        push(32'h77E7E, 24'h445566); push(32'h77E7F, 24'h445566);
        issue(638, 479, 10, 4, 24'h445566);
        wait_done("t3", 200, lat);
        check("t3_pix", 32'(pix_count), 2);
        check("t3_psel_cycles", 32'(psel_cyc), 4);
        check("t3_q_empty", 32'(exp_q.size()), 0);

        // 4: empty rectangles produce no traffic and finish one cycle after accept
        issue(4, 4, 0, 5, 24'h010203);
        wait_done("t4a", 20, lat);
        check("t4a_latency", 32'(lat), 1);
        check("t4a_psel_cycles", 32'(psel_cyc), 0);
        check("t4a_pix", 32'(pix_count), 0);
        issue(700, 4, 5, 5, 24'h010203);
        wait_done("t4b", 20, lat);
        check("t4b_latency", 32'(lat), 1);
        check("t4b_psel_cycles", 32'(psel_cyc), 0);
        check("t4b_done_pulses", 32'(done_cnt), 1);

        // 5: slave error on the second write
        err_idx = 1;
        push_rect(20, 30, 4, 1, 24'h0F0F0F);
        issue(20, 30, 4, 1, 24'h0F0F0F);
        wait_done("t5", 200, lat);
`ifdef FILL_PSLVERR_ABORT_EN
        check("t5_err", 32'(err), 1);
        check("t5_pix", 32'(pix_count), 1);
        check("t5_psel_cycles", 32'(psel_cyc), 4);
        check("t5_q_left", 32'(exp_q.size()), 2);
        exp_q.delete();
`else
        check("t5_err", 32'(err), 0);
        check("t5_pix", 32'(pix_count), 4);
        check("t5_psel_cycles", 32'(psel_cyc), 8);
        check("t5_q_empty", 32'(exp_q.size()), 0);
`endif
        err_idx = -1;

        // 6: reset during ACCESS of a long fill, then a fresh command
        wait_cycles = 2;
        push_rect(100, 100, 100, 1, 24'h777777);
        issue(100, 100, 100, 1, 24'h777777);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!(bus.out_psel && bus.out_penable) && lat < 50);
        if (!(bus.out_psel && bus.out_penable)) fail_now("t6_access_timeout");
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("t6_psel", 32'(bus.out_psel), 0);
        check("t6_penable", 32'(bus.out_penable), 0);
        check("t6_ready", 32'(bus.cmd_ready), 1);
        check("t6_busy", 32'(busy), 0);
        check("t6_pix", 32'(pix_count), 0);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        wait_cycles = 0;
        push(32'h0803, 24'h123456); push(32'h0804, 24'h123456);
        issue(3, 2, 2, 1, 24'h123456);
        wait_done("t6b", 200, lat);
        check("t6b_pix", 32'(pix_count), 2);
        check("t6b_q_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
